// File: rtl/ser_to_par.sv
// Serial-to-parallel receiver: LSB-first word, trailing parity bit, then a
// single-cycle write strobe of the received word to a downstream register.
module ser_to_par #(
    parameter int unsigned numbits = 7,
    parameter int unsigned parodd  = 0
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               SIN,
    input  logic               SVALID,
    input  logic               START,
    output logic [numbits:0]   DATA,
    output logic               EWR,
    output logic               BUSY,
    output logic               ERR
);

    localparam int unsigned CW = (numbits > 0) ? $clog2(numbits + 1) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PAR   = 2'd2;
    localparam logic [1:0] LOAD  = 2'd3;

    logic [1:0]        state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [numbits:0]  shreg, shreg_nx;
    logic [numbits:0]  data_nx;
    logic              ewr_nx, err_nx, busy_nx;
    logic              par_ok;

    // Parity of the collected word together with the received parity bit.
    assign par_ok = ((^shreg) ^ SIN) == 1'(parodd);

    // State and output registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            DATA  <= '0;
            EWR   <= 1'b0;
            ERR   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shreg <= shreg_nx;
            DATA  <= data_nx;
            EWR   <= ewr_nx;
            ERR   <= err_nx;
            BUSY  <= busy_nx;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        data_nx  = DATA;
        ewr_nx   = 1'b0;
        err_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (START) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                end
            end
            SHIFT: begin
                if (START) begin
                    // Abort: restart the frame, report the lost one.
                    err_nx = 1'b1;
                    cnt_nx = '0;
                end else if (SVALID) begin
                    shreg_nx = {SIN, shreg[numbits:1]};
                    if (cnt == CW'(numbits)) begin
                        state_nx = PAR;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            PAR: begin
                if (START) begin
                    err_nx   = 1'b1;
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                end else if (SVALID) begin
                    if (par_ok) begin
                        state_nx = LOAD;
                        data_nx  = shreg;
                        ewr_nx   = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                    end
                end
            end
            LOAD: begin
                cnt_nx   = '0;
                state_nx = START ? SHIFT : IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_ser_to_par.sv
// Directed bench for ser_to_par: an 8-bit even-parity instance and a 4-bit
// odd-parity instance driven from hand-built frames.
module tb_ser_to_par;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin8, sv8, st8;
    logic [7:0] data8;
    logic       ewr8, busy8, err8;
    logic       sin4, sv4, st4;
    logic [3:0] data4;
    logic       ewr4, busy4, err4;

    int total = 0;
    int bad   = 0;
    int ewr8_n = 0, err8_n = 0, ewr4_n = 0, err4_n = 0, excl_n = 0;
    int e0, r0;

    always #5 clk = ~clk;

    ser_to_par #(.numbits(7), .parodd(0)) u_dut8 (
        .CLOCK(clk), .RESET(rst), .SIN(sin8), .SVALID(sv8), .START(st8),
        .DATA(data8), .EWR(ewr8), .BUSY(busy8), .ERR(err8)
    );

    ser_to_par #(.numbits(3), .parodd(1)) u_dut4 (
        .CLOCK(clk), .RESET(rst), .SIN(sin4), .SVALID(sv4), .START(st4),
        .DATA(data4), .EWR(ewr4), .BUSY(busy4), .ERR(err4)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (ewr8) ewr8_n <= ewr8_n + 1;
        if (err8) err8_n <= err8_n + 1;
        if (ewr4) ewr4_n <= ewr4_n + 1;
        if (err4) err4_n <= err4_n + 1;
        if ((ewr8 && err8) || (ewr4 && err4)) excl_n <= excl_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start8();
        st8 = 1'b1; sv8 = 1'b0;
        tick();
        st8 = 1'b0;
    endtask

    task automatic bit8(input logic b, input int gap);
        sv8 = 1'b0;
        repeat (gap) tick();
        sin8 = b; sv8 = 1'b1;
        tick();
        sv8 = 1'b0;
    endtask

    task automatic bits8(input logic [7:0] w, input int n, input int maxgap);
        for (int i = 0; i < n; i++)
            bit8(w[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    task automatic bit4(input logic b);
        sin4 = b; sv4 = 1'b1;
        tick();
        sv4 = 1'b0;
    endtask

    task automatic word4(input logic [3:0] w);
        for (int i = 0; i < 4; i++) bit4(w[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        sin8 = 0; sv8 = 0; st8 = 0;
        sin4 = 0; sv4 = 0; st4 = 0;
        tick(); tick();
        check_eq("rst_data8", 32'(data8), 32'h0);
        check_eq("rst_busy8", 32'(busy8), 32'h0);
        check_eq("rst_ewr8",  32'(ewr8),  32'h0);
        check_eq("rst_err8",  32'(err8),  32'h0);
        rst = 1'b0;
        sv8 = 1'b1; sin8 = 1'b1;
        tick(); tick();
        check_eq("idle_hold", 32'(busy8), 32'h0);
        sv8 = 1'b0;

        // Bad parity on 0xA5: error pulse, DATA untouched.
        start8();
        check_eq("start_busy", 32'(busy8), 32'h1);
        bits8(8'hA5, 8, 0);
        bit8(1'b1, 0);
        check_eq("par_err", 32'(err8), 32'h1);
        check_eq("par_err_noewr", 32'(ewr8), 32'h0);
        check_eq("par_err_data", 32'(data8), 32'h0);
        check_eq("par_err_idle", 32'(busy8), 32'h0);
        tick();
        check_eq("par_err_1cyc", 32'(err8), 32'h0);

        // Good frame 0xA5, back-to-back bits.
        e0 = ewr8_n; r0 = err8_n;
        start8();
        bits8(8'hA5, 8, 0);
        bit8(1'b0, 0);
        check_eq("a5_ewr", 32'(ewr8), 32'h1);
        check_eq("a5_data", 32'(data8), 32'hA5);
        check_eq("a5_err", 32'(err8), 32'h0);
        check_eq("a5_busy_load", 32'(busy8), 32'h1);
        tick();
        check_eq("a5_ewr_off", 32'(ewr8), 32'h0);
        check_eq("a5_busy_off", 32'(busy8), 32'h0);
        check_eq("a5_hold", 32'(data8), 32'hA5);
        check_eq("a5_ewr_cnt", 32'(ewr8_n - e0), 32'h1);
        check_eq("a5_err_cnt", 32'(err8_n - r0), 32'h0);

        // 0x3C with random SVALID gaps.
        e0 = ewr8_n;
        start8();
        bits8(8'h3C, 8, 5);
        bit8(1'b0, 3);
        check_eq("3c_ewr", 32'(ewr8), 32'h1);
        check_eq("3c_data", 32'(data8), 32'h3C);
        tick(); tick();
        check_eq("3c_ewr_cnt", 32'(ewr8_n - e0), 32'h1);

        // Abort after 4 bits, then full 0x81 frame.
        e0 = ewr8_n; r0 = err8_n;
        start8();
        bits8(8'h0B, 4, 0);
        start8();
        check_eq("abort_err", 32'(err8), 32'h1);
        check_eq("abort_busy", 32'(busy8), 32'h1);
        check_eq("abort_data", 32'(data8), 32'h3C);
        bits8(8'h81, 8, 0);
        bit8(1'b0, 0);
        check_eq("81_ewr", 32'(ewr8), 32'h1);
        check_eq("81_data", 32'(data8), 32'h81);
        tick();
        check_eq("81_err_cnt", 32'(err8_n - r0), 32'h1);
        check_eq("81_ewr_cnt", 32'(ewr8_n - e0), 32'h1);

        // Reset mid-frame after 5 bits, then 0x0F.
        e0 = ewr8_n; r0 = err8_n;
        start8();
        bits8(8'h15, 5, 0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_data", 32'(data8), 32'h0);
        check_eq("arst_busy", 32'(busy8), 32'h0);
        check_eq("arst_ewr",  32'(ewr8),  32'h0);
        check_eq("arst_err",  32'(err8),  32'h0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        check_eq("post_rst_idle", 32'(busy8), 32'h0);
        check_eq("rst_no_err", 32'(err8_n - r0), 32'h0);
        check_eq("rst_no_ewr", 32'(ewr8_n - e0), 32'h0);
        start8();
        bits8(8'h0F, 8, 0);
        bit8(1'b0, 0);
        check_eq("0f_ewr", 32'(ewr8), 32'h1);
        check_eq("0f_data", 32'(data8), 32'h0F);
        tick();
        check_eq("0f_err_cnt", 32'(err8_n - r0), 32'h0);

        // Odd parity, 4-bit word, START held through LOAD.
        st4 = 1'b1; tick(); st4 = 1'b0;
        word4(4'h6);
        bit4(1'b1);
        check_eq("w6_ewr", 32'(ewr4), 32'h1);
        check_eq("w6_data", 32'(data4), 32'h6);
        st4 = 1'b1;
        tick();
        st4 = 1'b0;
        check_eq("w6_busy_chain", 32'(busy4), 32'h1);
        check_eq("w6_ewr_off", 32'(ewr4), 32'h0);
        check_eq("w6_no_err", 32'(err4), 32'h0);
        word4(4'h9);
        bit4(1'b1);
        check_eq("w9_ewr", 32'(ewr4), 32'h1);
        check_eq("w9_data", 32'(data4), 32'h9);
        tick(); tick();
        check_eq("w4_ewr_cnt", 32'(ewr4_n), 32'h2);
        check_eq("w4_err_cnt", 32'(err4_n), 32'h0);
        check_eq("w4_idle", 32'(busy4), 32'h0);

        check_eq("ewr_err_excl", 32'(excl_n), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ser_to_par.md
SER_TO_PAR -- requirements
Module: ser_to_par

Interface
REQ-001 The block SHALL have parameter: numbits, default 7, MSB index of the parallel word (word width numbits+1).
REQ-002 The block SHALL have parameter: parodd, default 0, parity sense (0 = even, 1 = odd).
REQ-003 The block SHALL have one clock and one reset; RESET is asynchronous and active-high.
REQ-004 The ports SHALL be:
- CLOCK  in  1  single clock; all state changes on its rising edge.
- RESET  in  1  asynchronous active-high reset.
- SIN  in  1  serial data bit.
- SVALID  in  1  SIN is valid this cycle (bit strobe).
- START  in  1  frame start request, sampled each cycle.
- DATA  out  numbits+1  last correctly received word; feeds the downstream parallel register DATA input.
- EWR  out  1  one-cycle write strobe to the downstream register; DATA is valid while EWR=1.
- BUSY  out  1  frame in progress (state not IDLE).
- ERR  out  1  one-cycle error pulse (parity fail or aborted frame).

Function
REQ-005 The FSM SHALL have states IDLE, SHIFT, PAR and LOAD, plus a bit counter of width ceil(log2(numbits+1)) and a shift register of numbits+1 bits.
REQ-006 In IDLE, START=1 SHALL move the FSM to SHIFT with counter=0; SVALID in that same cycle SHALL be ignored.
REQ-007 In IDLE, START=0 SHALL keep the FSM in IDLE and ignore SVALID/SIN.
REQ-008 In SHIFT, each cycle with SVALID=1 SHALL shift SIN in LSB-first (shreg <= {SIN, shreg[numbits:1]}) and increment the counter.
REQ-009 In SHIFT, cycles with SVALID=0 SHALL hold shreg and the counter; gaps of any length are legal.
REQ-010 In SHIFT, SVALID=1 with counter==numbits SHALL shift the last bit in and move the FSM to PAR.
REQ-011 In PAR, SVALID=1 SHALL sample SIN as the parity bit; parity passes when XOR(shreg, SIN) == parodd.
- On pass: the FSM moves to LOAD.
- On fail: ERR pulses for one cycle, the FSM moves to IDLE, and DATA is unchanged.
REQ-012 Entering LOAD SHALL register DATA <= shreg and EWR <= 1 on the same edge, so EWR is high exactly one cycle, starting the cycle after the parity-bit sample.
REQ-013 LOAD SHALL last exactly one cycle: EWR returns to 0, and the FSM goes to SHIFT if START=1 in the LOAD cycle, otherwise to IDLE.
REQ-014 START=1 in SHIFT or PAR SHALL abort the frame: ERR pulses one cycle, the FSM restarts in SHIFT with counter=0, SVALID in that cycle is ignored, and DATA is unchanged.
REQ-015 DATA SHALL change only on entry to LOAD and SHALL hold its value otherwise.
REQ-016 BUSY SHALL be 1 in SHIFT, PAR and LOAD, and 0 in IDLE.
REQ-017 EWR and ERR SHALL never both be 1 in the same cycle.
REQ-018 All outputs SHALL be registered or decoded from registered state only, with no combinational path from SIN/SVALID/START to outputs.

Reset
REQ-019 RESET=1 SHALL immediately force, independent of CLOCK: state=IDLE, counter=0, shreg=0, DATA=0, EWR=0, BUSY=0, ERR=0.
REQ-020 Reset asserted mid-frame SHALL discard the partial word with no EWR and no ERR pulse.
REQ-021 After RESET deasserts, the FSM SHALL remain in IDLE until START=1.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Even parity, numbits=7: START, then bits of 0xA5 LSB-first, back-to-back, then parity 0 -> EWR=1 for one cycle one cycle after the parity sample, DATA=0xA5, ERR=0, BUSY=0 two cycles after the parity sample.
- Same frame 0xA5 with parity bit 1 -> ERR one-cycle pulse, no EWR, DATA holds its previous value (0 after reset).
- 0x3C sent with random 0-5 cycle SVALID gaps, correct parity 0 -> DATA=0x3C with exactly one EWR pulse; bit order is unaffected by the gaps.
- START reasserted after 4 bits of a frame, then a full 0x81 frame with parity 0 -> one ERR pulse at the abort, then EWR with DATA=0x81.
- RESET pulsed after 5 bits of a frame, then a full 0x0F frame -> all outputs 0 during reset, no ERR, one EWR with DATA=0x0F.
- parodd=1, numbits=3: word 0x6 with parity 1 -> EWR, DATA=0x6; START held high during LOAD -> BUSY stays 1 and the next frame is accepted without an IDLE cycle.
